// File: rtl/instruction_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue.
interface instruction_queue_if #(
  parameter int unsigned WIDTH = 32
);
  logic             pushValid;
  logic [WIDTH-1:0] pushPc;
  logic [WIDTH-1:0] pushInstruction;
  logic             pushReady;
  logic             popReady;
  logic             popValid;
  logic [WIDTH-1:0] popPc;
  logic [WIDTH-1:0] popInstruction;

  // Queue side: consumes pushes, presents the head entry.
  modport slave (
    input  pushValid, pushPc, pushInstruction, popReady,
    output pushReady, popValid, popPc, popInstruction
  );

  // Fetch/decode side: drives pushes and pop acceptance.
  modport master (
    output pushValid, pushPc, pushInstruction, popReady,
    input  pushReady, popValid, popPc, popInstruction
  );
endinterface

// File: rtl/instruction_queue.sv
// Circular-buffer instruction queue between fetch and decode, with flush.
module instruction_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_queue_if.slave         q_if,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] pc_mem_q  [DEPTH];
  logic [WIDTH-1:0] pc_mem_d  [DEPTH];
  logic [WIDTH-1:0] ins_mem_q [DEPTH];
  logic [WIDTH-1:0] ins_mem_d [DEPTH];

  logic full_c;
  logic empty_c;
  logic do_push_c;
  logic do_pop_c;

  // Handshake qualification from registered occupancy only; flush overrides both.
  always_comb begin
    full_c    = (count_q == CNT_W'(DEPTH));
    empty_c   = (count_q == '0);
    do_push_c = q_if.pushValid && !full_c && !flush;
    do_pop_c  = q_if.popReady && !empty_c && !flush;
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pc_mem_d  = pc_mem_q;
    ins_mem_d = ins_mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) begin
        pc_mem_d[wr_ptr_q]  = q_if.pushPc;
        ins_mem_d[wr_ptr_q] = q_if.pushInstruction;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push_c && !do_pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop_c && !do_push_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers; reset clears pointers, count and storage immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pc_mem_q  <= pc_mem_d;
      ins_mem_q <= ins_mem_d;
    end
  end

  // Head entry is presented combinationally; empty queue shows a zero NOP.
  always_comb begin
    q_if.pushReady      = !full_c;
    q_if.popValid       = !empty_c;
    q_if.popPc          = empty_c ? '0 : pc_mem_q[rd_ptr_q];
    q_if.popInstruction = empty_c ? '0 : ins_mem_q[rd_ptr_q];
    count               = count_q;
  end

endmodule
